// File: rtl/ctrl_sequencer_pkg.sv
// Shared controller definitions for the upsampler sequencer: state encoding and default widths.
package ctrl_sequencer_pkg;

  localparam int unsigned PAWIDTH_DEF  = 6;
  localparam int unsigned TMOWIDTH_DEF = 8;
  localparam int unsigned STATE_W      = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

endpackage

// File: rtl/ctrl_wdog.sv
// vec_done watchdog: counter with clear/increment; tc_c flags that the next increment reaches all-ones.
module ctrl_wdog #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;

  assign cnt_inc = cnt + W'(1);
  assign tc_c    = &cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Program sequencer: on each input sample walks instruction memory from address 0,
// issuing one datapath vector per instruction until the last-stage instruction completes.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int unsigned PAWIDTH  = PAWIDTH_DEF,
  parameter int unsigned TMOWIDTH = TMOWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_vld,
  output logic               imem_ren,
  output logic [PAWIDTH-1:0] imem_addr,
  output logic               fetch,
  input  logic               lstg_f,
  input  logic               upse_f,
  output logic               vec_start,
  input  logic               vec_done,
  output logic               out_vld,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  state_t             state;
  state_t             state_nxt;
  logic [PAWIDTH-1:0] pc;
  logic [PAWIDTH-1:0] pc_nxt;
  logic               pending;
  logic               pending_nxt;
  logic               wdog_clr;
  logic               wdog_inc;
  logic               wdog_tc_c;

  ctrl_wdog #(
    .W (TMOWIDTH)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wdog_clr),
    .inc  (wdog_inc),
    .tc_c (wdog_tc_c)
  );

  assign imem_addr = pc;

  // State, pc, sample queue and the state-decoded strobes (loaded from next state so they align with it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      pending   <= 1'b0;
      imem_ren  <= 1'b0;
      fetch     <= 1'b0;
      vec_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      pending   <= pending_nxt;
      imem_ren  <= (state_nxt == S_READ);
      fetch     <= (state_nxt == S_LOAD);
      vec_start <= (state_nxt == S_START);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // Next-state logic and the completion/error pulses, which must coincide with vec_done.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending;
    wdog_clr    = 1'b0;
    wdog_inc    = 1'b0;
    out_vld     = 1'b0;
    frame_done  = 1'b0;
    timeout     = 1'b0;
    overrun     = 1'b0;

    case (state)
      S_IDLE: begin
        if (sample_vld || pending) begin
          state_nxt = S_READ;
        end
        // A queued sample is consumed here; a fresh one arriving now takes its place.
        if (pending) begin
          pending_nxt = sample_vld;
          overrun     = sample_vld;
        end
      end
      S_READ: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_WAIT;
        wdog_clr  = 1'b1;
      end
      S_WAIT: begin
        if (vec_done) begin
          out_vld = upse_f;
          if (lstg_f) begin
            frame_done = 1'b1;
            pc_nxt     = '0;
            state_nxt  = S_IDLE;
          end else begin
            pc_nxt    = pc + PAWIDTH'(1);
            state_nxt = S_READ;
          end
        end else if (wdog_tc_c) begin
          timeout   = 1'b1;
          pc_nxt    = '0;
          state_nxt = S_IDLE;
        end else begin
          wdog_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = '0;
      end
    endcase

    if ((state != S_IDLE) && sample_vld) begin
      pending_nxt = 1'b1;
      overrun     = pending;
    end

    // Reset aborts at once: no pulses escape in the reset cycle.
    if (rst) begin
      out_vld    = 1'b0;
      frame_done = 1'b0;
      timeout    = 1'b0;
      overrun    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer with a 4-word instruction RAM and fetch register model.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst;
  logic       sample_vld;
  logic       imem_ren;
  logic [1:0] imem_addr;
  logic       fetch;
  logic       lstg_f;
  logic       upse_f;
  logic       vec_start;
  logic       vec_done;
  logic       out_vld;
  logic       frame_done;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int vectors;
  int miscompares;
  int cyc;
  int t_sv;
  int t_fd;

  logic lstg_mem [4];
  logic upse_mem [4];
  logic rd_l;
  logic rd_u;

  ctrl_sequencer #(
    .PAWIDTH  (2),
    .TMOWIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_vld (sample_vld),
    .imem_ren   (imem_ren),
    .imem_addr  (imem_addr),
    .fetch      (fetch),
    .lstg_f     (lstg_f),
    .upse_f     (upse_f),
    .vec_start  (vec_start),
    .vec_done   (vec_done),
    .out_vld    (out_vld),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction RAM (1-cycle read latency) followed by the fetch register.
  always @(posedge clk) begin
    if (imem_ren) begin
      rd_l <= lstg_mem[imem_addr];
      rd_u <= upse_mem[imem_addr];
    end
    if (fetch) begin
      lstg_f <= rd_l;
      upse_f <= rd_u;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic vd);
    sample_vld = sv;
    vec_done   = vd;
    #1;
  endtask

  task automatic idle_cyc(input logic sv, input logic exp_ovr);
    drive(sv, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ren", imem_ren, 1'b0);
    chk1("idle_ovr", overrun, exp_ovr);
    if (sv) t_sv = cyc;
    tick();
  endtask

  task automatic front(input int addr, input int sv_at, input logic exp_ovr, input logic vd_in_start);
    drive(sv_at == 0, 1'b0);
    chk1("read_ren", imem_ren, 1'b1);
    chkn("read_addr", 32'(imem_addr), 32'(addr));
    chk1("read_ovr", overrun, (sv_at == 0) ? exp_ovr : 1'b0);
    tick();
    drive(sv_at == 1, 1'b0);
    chk1("load_fetch", fetch, 1'b1);
    chk1("load_ovr", overrun, (sv_at == 1) ? exp_ovr : 1'b0);
    tick();
    drive(sv_at == 2, vd_in_start);
    chk1("start_vs", vec_start, 1'b1);
    chk1("start_ovr", overrun, (sv_at == 2) ? exp_ovr : 1'b0);
    chk1("start_ov", out_vld, 1'b0);
    tick();
  endtask

  task automatic instr(input int addr, input int nwait, input logic exp_ov, input logic exp_fd,
                       input int sv_at, input logic exp_ovr, input logic vd_in_start);
    front(addr, sv_at, exp_ovr, vd_in_start);
    for (int i = 1; i < nwait; i++) begin
      drive(1'b0, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      chk1("wait_ren", imem_ren, 1'b0);
      chk1("wait_ov", out_vld, 1'b0);
      tick();
    end
    drive(sv_at == 3, 1'b1);
    chk1("done_out_vld", out_vld, exp_ov);
    chk1("done_frame", frame_done, exp_fd);
    chk1("done_ovr", overrun, (sv_at == 3) ? exp_ovr : 1'b0);
    if (exp_fd) t_fd = cyc;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    t_sv        = 0;
    t_fd        = 0;
    for (int i = 0; i < 4; i++) begin
      lstg_mem[i] = 1'b0;
      upse_mem[i] = 1'b0;
    end
    lstg_mem[2] = 1'b1;
    upse_mem[1] = 1'b1;
    rst        = 1'b1;
    sample_vld = 1'b0;
    vec_done   = 1'b0;
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ren", imem_ren, 1'b0);
    chkn("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;

    // Basic 3-instruction program and its sample-to-frame_done latency.
    idle_cyc(1'b1, 1'b0);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    instr(1, 2, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    instr(2, 2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    chkn("latency", 32'(t_fd - t_sv), 32'd15);
    idle_cyc(1'b0, 1'b0);

    // Queued sample, then a third sample overflows the queue.
    idle_cyc(1'b1, 1'b0);
    instr(0, 2, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    instr(1, 2, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    instr(2, 2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    idle_cyc(1'b1, 1'b1);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    instr(1, 3, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    instr(2, 2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    instr(1, 2, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    instr(2, 2, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b1);
    instr(1, 2, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    instr(2, 2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0);

    // Watchdog: second instruction never completes.
    idle_cyc(1'b1, 1'b0);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    front(1, -1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b0);
      chk1("tmo_pulse", timeout, i == 15);
      chk1("tmo_frame", frame_done, 1'b0);
      tick();
    end
    chkn("tmo_addr", 32'(imem_addr), 32'd0);
    idle_cyc(1'b0, 1'b0);

    // No last-stage flag: pc wraps 3 -> 0, then reset lands mid-wait.
    lstg_mem[2] = 1'b0;
    idle_cyc(1'b1, 1'b0);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    instr(1, 2, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    instr(2, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    instr(3, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    instr(0, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    front(1, -1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1);
    chk1("rstw_out_vld", out_vld, 1'b0);
    chk1("rstw_frame", frame_done, 1'b0);
    chk1("rstw_tmo", timeout, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    chk1("rstw_busy", busy, 1'b0);
    chkn("rstw_addr", 32'(imem_addr), 32'd0);
    chk1("rstw_vs", vec_start, 1'b0);
    chk1("rstw_fetch", fetch, 1'b0);
    tick();
    rst = 1'b0;
    idle_cyc(1'b0, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
